// File: rtl/fiapp_sig_compactor.sv
// fiapp_sig_compactor
// Response compactor for the fault-injection test application. During a
// measurement window it folds the observed outputs {o4, o3, o2, o1} into a
// 32-bit Galois MISR. When the window ends it compares the signature with a
// golden value, so each injection run reports one pass/fail bit and one word.
module fiapp_sig_compactor #(
  parameter int              SIG_W = 32,
  parameter int              CNT_W = 16,
  parameter logic [31:0]     POLY  = 32'h04C11DB7,
  parameter logic [31:0]     SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic             o1,
  input  logic             o2,
  input  logic             o3,
  input  logic [64:0]      o4,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             match,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Fold the 68-bit observation vector down to 32 bits. The top four bits
  // (o4[64:61]) land in the low nibble so every observed bit reaches the MISR.
  function automatic logic [31:0] foldVec(input logic [67:0] v);
    foldVec = v[31:0] ^ v[63:32] ^ {28'h0000000, v[67:64]};
  endfunction

  // One Galois MISR step: shift, conditional polynomial feedback, inject fold.
  function automatic logic [31:0] misrStep(input logic [31:0] sig,
                                           input logic [31:0] f);
    misrStep = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h00000000) ^ f;
  endfunction

  state_t             state_r;
  state_t             stateNext_s;
  logic [SIG_W-1:0]   sig_r;
  logic [SIG_W-1:0]   sigNext_s;
  logic [CNT_W-1:0]   vecCount_r;
  logic [CNT_W-1:0]   vecCountNext_s;
  logic [CNT_W-1:0]   remaining_r;
  logic [CNT_W-1:0]   remainingNext_s;
  logic [67:0]        obsVec_s;

  assign obsVec_s = {o4, o3, o2, o1};

  // Next-state and datapath next values; abort overrides everything else.
  always_comb begin
    stateNext_s     = state_r;
    sigNext_s       = sig_r;
    vecCountNext_s  = vecCount_r;
    remainingNext_s = remaining_r;
    if (abort) begin
      stateNext_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            sigNext_s      = SEED;
            vecCountNext_s = CNT_ZERO;
            if (n_cycles != CNT_ZERO) begin
              remainingNext_s = n_cycles;
              stateNext_s     = RUN;
            end else begin
              remainingNext_s = CNT_ZERO;
              stateNext_s     = DONE;
            end
          end else begin
            stateNext_s = state_r;
          end
        end
        RUN: begin
          sigNext_s = misrStep(sig_r, foldVec(obsVec_s));
          if (vecCount_r != CNT_MAX) begin
            vecCountNext_s = vecCount_r + CNT_ONE;
          end else begin
            vecCountNext_s = vecCount_r;
          end
          if (remaining_r > CNT_ONE) begin
            remainingNext_s = remaining_r - CNT_ONE;
            stateNext_s     = RUN;
          end else begin
            // Last step (or a defensive zero) ends the window without underflow.
            remainingNext_s = CNT_ZERO;
            stateNext_s     = DONE;
          end
        end
        default: begin
          stateNext_s     = IDLE;
          remainingNext_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State, signature and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sig_r       <= SEED;
      vecCount_r  <= CNT_ZERO;
      remaining_r <= CNT_ZERO;
    end else begin
      state_r     <= stateNext_s;
      sig_r       <= sigNext_s;
      vecCount_r  <= vecCountNext_s;
      remaining_r <= remainingNext_s;
    end
  end

  assign busy      = (state_r == RUN);
  assign done      = (state_r == DONE);
  assign signature = sig_r;
  assign vec_count = vecCount_r;
  assign match     = done & (sig_r == golden);

endmodule

// File: tb/tb_fiapp_sig_compactor.sv
// tb_fiapp_sig_compactor
// Directed bench: one instance with the default SEED, one with SEED=0 so the
// fold mapping can be read directly from the signature.
module tb_fiapp_sig_compactor;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] n_cycles;
  logic        o1, o2, o3;
  logic [64:0] o4;
  logic [31:0] golden;

  logic        busyA, doneA, matchA;
  logic [31:0] sigA;
  logic [15:0] vecA;
  logic        busyB, doneB, matchB;
  logic [31:0] sigB;
  logic [15:0] vecB;

  int nCompared   = 0;
  int nMismatched = 0;

  fiapp_sig_compactor dutA (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_cycles(n_cycles), .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .golden(golden), .busy(busyA), .done(doneA), .signature(sigA),
    .match(matchA), .vec_count(vecA)
  );

  fiapp_sig_compactor #(.SEED(32'h00000000)) dutB (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_cycles(n_cycles), .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .golden(golden), .busy(busyB), .done(doneB), .signature(sigB),
    .match(matchB), .vec_count(vecB)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus and checks.
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    n_cycles = 16'd0;
    o1 = 1'b0; o2 = 1'b0; o3 = 1'b0;
    o4       = 65'd0;
    golden   = 32'hFFFFFFFF;
    #3;
    checkVal("rst sigA", sigA, 64'hFFFFFFFF);
    checkVal("rst sigB", sigB, 64'h0);
    checkVal("rst busy", busyA, 64'd0);
    checkVal("rst done", doneA, 64'd0);
    checkVal("rst match", matchA, 64'd0);
    checkVal("rst vec", vecA, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // n_cycles=1, all inputs zero
    start = 1'b1; n_cycles = 16'd1;
    tick();
    start = 1'b0;
    checkVal("t1 busy", busyA, 64'd1);
    tick();
    checkVal("t1 done", doneA, 64'd1);
    checkVal("t1 busy off", busyA, 64'd0);
    checkVal("t1 sigA", sigA, 64'hFB3EE249);
    checkVal("t1 vecA", vecA, 64'd1);
    checkVal("t1 sigB", sigB, 64'h0);
    golden = 32'hFB3EE249;
    #1;
    checkVal("t1 match", matchA, 64'd1);
    golden = 32'h00000000;
    #1;
    checkVal("t1 nomatch", matchA, 64'd0);

    // SEED=0, o1 held, two vectors
    o1 = 1'b1; start = 1'b1; n_cycles = 16'd2;
    tick();
    start = 1'b0;
    tick();
    checkVal("t2 sig1", sigB, 64'h1);
    checkVal("t2 vec1", vecB, 64'd1);
    checkVal("t2 notdone", doneB, 64'd0);
    tick();
    checkVal("t2 sig2", sigB, 64'h3);
    checkVal("t2 done", doneB, 64'd1);
    o1 = 1'b0;

    // Wide-boundary fold: o4[64] -> v[67] -> bit 3
    o4 = {1'b1, 64'h0}; start = 1'b1; n_cycles = 16'd1;
    tick();
    start = 1'b0;
    tick();
    checkVal("t3 o4[64]", sigB, 64'h8);
    // o4[28] -> v[31]
    o4 = 65'd0;
    o4[28] = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkVal("t3 o4[28]", sigB, 64'h80000000);
    o4 = 65'd0;

    // n_cycles=0 goes straight to DONE
    start = 1'b1; n_cycles = 16'd0;
    tick();
    start = 1'b0;
    checkVal("t4 done", doneA, 64'd1);
    checkVal("t4 busy", busyA, 64'd0);
    checkVal("t4 sig", sigA, 64'hFFFFFFFF);
    checkVal("t4 vec", vecA, 64'd0);

    // Abort with the 3rd compaction edge of a 5-vector window
    start = 1'b1; n_cycles = 16'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkVal("t5 vec2", vecA, 64'd2);
    checkVal("t5 sig2", sigA, 64'hF2BCD925);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkVal("t5 ab busy", busyA, 64'd0);
    checkVal("t5 ab done", doneA, 64'd0);
    checkVal("t5 ab vec", vecA, 64'd2);
    checkVal("t5 ab sig", sigA, 64'hF2BCD925);
    start = 1'b1; n_cycles = 16'd1;
    tick();
    start = 1'b0;
    tick();
    checkVal("t5 restart sig", sigA, 64'hFB3EE249);
    checkVal("t5 restart vec", vecA, 64'd1);
    checkVal("t5 restart done", doneA, 64'd1);

    // Async reset in the middle of a window
    start = 1'b1; n_cycles = 16'd4;
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkVal("t6 rst busy", busyA, 64'd0);
    checkVal("t6 rst sig", sigA, 64'hFFFFFFFF);
    checkVal("t6 rst vec", vecA, 64'd0);
    checkVal("t6 rst done", doneA, 64'd0);
    #1;
    reset = 1'b0;

    // start pulsed during RUN is ignored
    start = 1'b1; n_cycles = 16'd4;
    tick();
    n_cycles = 16'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkVal("t7 busy", busyA, 64'd1);
    checkVal("t7 vec3", vecA, 64'd3);
    checkVal("t7 notdone", doneA, 64'd0);
    tick();
    checkVal("t7 done", doneA, 64'd1);
    checkVal("t7 vec4", vecA, 64'd4);
    tick();
    checkVal("t7 hold vec", vecA, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fiapp_sig_compactor.md
Name: fiapp_sig_compactor

Overview:
- Downstream response compactor for the fault-injection test application.
- Samples the application's observable outputs (o1, o2, o3, 65-bit o4) every cycle of a measurement window. Folds them into a 32-bit multiple-input signature register (MISR).
- At window end, compares the signature against a golden value, so an injection campaign needs only one pass/fail bit and one 32-bit word per run.

Parameters:
- SIG_W, 32, signature width (fixed fold below assumes 32)
- CNT_W, 16, width of window-length and vector counters
- POLY, 32'h04C11DB7, MISR feedback polynomial (Galois form)
- SEED, 32'hFFFFFFFF, signature value loaded on reset and on start

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  pulse: begin a new window (honoured in IDLE and DONE only)
- abort  in  1  pulse: terminate window, return to IDLE
- n_cycles  in  CNT_W  window length in vectors, sampled with start
- o1  in  1  observed application output
- o2  in  1  observed application output
- o3  in  1  observed application output
- o4  in  65  observed application wide output
- golden  in  SIG_W  expected signature, compared continuously while done=1
- busy  out  1  high in RUN
- done  out  1  high in DONE
- signature  out  SIG_W  current MISR contents
- match  out  1  done & (signature == golden)
- vec_count  out  CNT_W  vectors compacted in current/last window

Behaviour:
- Reset (async, any time, including mid-window):
  - state=IDLE, signature=SEED, vec_count=0, remaining=0.
  - busy=0, done=0, match=0.
- Input vector: v[67:0] = {o4, o3, o2, o1}.
  - Bit mapping: o1 -> v[0], o2 -> v[1], o3 -> v[2], o4[64:0] -> v[67:3].
- Fold: f = v[31:0] ^ v[63:32] ^ {28'b0, v[67:64]}.
- MISR step: sig_next = (sig << 1) ^ (sig[31] ? POLY : 0) ^ f, truncated to 32 bits.
- IDLE:
  - start with n_cycles != 0: signature <= SEED, remaining <= n_cycles, vec_count <= 0, go RUN.
  - start with n_cycles == 0: signature <= SEED, vec_count <= 0, go DONE directly (signature = SEED).
- RUN: each rising edge performs one MISR step on the current v, vec_count++, remaining--.
  - The edge where remaining==1 performs the last step and enters DONE.
  - Start is sampled at edge k; vectors present at edges k+1 .. k+N are compacted; done rises after edge k+N.
  - start is ignored while in RUN.
- DONE: signature, vec_count frozen; done=1; match tracks golden combinationally.
  - start restarts exactly as from IDLE.
- abort, any state: next state IDLE; signature and vec_count hold; done=0.
  - abort has priority over start and over the RUN step in the same cycle: no compaction on that edge.
- vec_count saturates at all-ones (only reachable if CNT_W is reduced below the log2 of n_cycles). It never wraps.
- remaining never underflows.
- No X propagation: all inputs are used only in RUN; outputs are defined from reset.

Test Plan:
- Reset, start with n_cycles=1, all observed inputs 0 -> one edge later done=1, signature=32'hFB3EE249, vec_count=1; golden=32'hFB3EE249 -> match=1; golden=0 -> match=0.
- SEED overridden to 0, o1=1 held, n_cycles=2 -> after the 1st step signature=32'h00000001, after the 2nd 32'h00000003; done rises on the edge after the 2nd vector.
- SEED=0, n_cycles=1, only o4[64]=1 -> signature=32'h00000008 (wide-boundary fold); only o4[28]=1 (v[31]) -> 32'h80000000.
- n_cycles=0 with start -> done=1 next cycle, signature=SEED, vec_count=0, busy never asserted.
- n_cycles=5, abort asserted together with the 3rd compaction edge -> IDLE, vec_count=2, signature holds the 2-step value, done=0. A following start restarts from SEED.
- Async reset asserted mid-RUN between edges -> outputs immediately IDLE/SEED/0. start pulsed during RUN (n_cycles=4) -> ignored, vec_count ends at 4.
